// File: rtl/backchannel_ctrl.sv
// Backchannel command sequencer: 0xAB streams the regfile to uart_tx, 0xAC streams
// a coherent snapshot of the most recent Thunderbolt time packet.
module backchannel_ctrl #(
   parameter int unsigned FILE_SIZE_BYTES  = 25,
   parameter logic [7:0]  CMD_DUMP_REG     = 8'hAB,
   parameter logic [7:0]  CMD_DUMP_THUNDER = 8'hAC
) (
   input  logic        i_clk_10,
   input  logic        i_rst_n,
   input  logic        i_rx_dv,
   input  logic [7:0]  i_rx_byte,
   output logic        o_tx_dv,
   output logic [7:0]  o_tx_byte,
   input  logic        i_tx_active,
   input  logic        i_tx_done,
   output logic        o_rd_en,
   output logic [7:0]  o_rd_addr,
   input  logic [7:0]  i_rd_byte,
   input  logic        i_thunder_packet_dv,
   input  logic [15:0] i_thunder_year,
   input  logic [7:0]  i_thunder_month,
   input  logic [7:0]  i_thunder_day,
   input  logic [7:0]  i_thunder_hour,
   input  logic [7:0]  i_thunder_minutes,
   input  logic [7:0]  i_thunder_seconds,
   output logic        o_busy
);
   localparam int unsigned PKT_BYTES = 7;
   localparam logic [7:0]  LAST_REG  = 8'(FILE_SIZE_BYTES - 1);
   localparam logic [7:0]  LAST_TB   = 8'(PKT_BYTES - 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, TX_LOAD, TX_WAIT, TB_LOAD} state_t;

   state_t     r_state;
   logic       r_is_reg;
   logic [7:0] r_idx;
   logic [7:0] r_byte;
   logic [7:0] r_rd_addr;
   logic       r_rd_en;
   logic       r_busy;
   logic [7:0] r_shadow [PKT_BYTES];
   logic [7:0] r_send   [PKT_BYTES];
   logic [7:0] w_pkt    [PKT_BYTES];
   logic       w_start_tb;
   logic       w_last;

   assign w_pkt[0] = i_thunder_year[15:8];
   assign w_pkt[1] = i_thunder_year[7:0];
   assign w_pkt[2] = i_thunder_month;
   assign w_pkt[3] = i_thunder_day;
   assign w_pkt[4] = i_thunder_hour;
   assign w_pkt[5] = i_thunder_minutes;
   assign w_pkt[6] = i_thunder_seconds;

   assign w_start_tb = (r_state == IDLE) && i_rx_dv && (i_rx_byte == CMD_DUMP_THUNDER);
   assign w_last     = (r_idx == (r_is_reg ? LAST_REG : LAST_TB));

   // Shadow follows every packet; the send buffer is frozen at command time so a
   // packet arriving mid-dump cannot tear the bytes being streamed.
   always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < PKT_BYTES; i++) begin
            r_shadow[i] <= '0;
            r_send[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < PKT_BYTES; i++) begin
            if (i_thunder_packet_dv) r_shadow[i] <= w_pkt[i];
            if (w_start_tb)          r_send[i]   <= i_thunder_packet_dv ? w_pkt[i] : r_shadow[i];
         end
      end
   end

   always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_is_reg  <= 1'b0;
         r_idx     <= '0;
         r_byte    <= '0;
         r_rd_addr <= '0;
         r_rd_en   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_rx_dv && (i_rx_byte == CMD_DUMP_REG)) begin
                  r_state   <= RD_REQ;
                  r_is_reg  <= 1'b1;
                  r_idx     <= '0;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_busy    <= 1'b1;
               end else if (w_start_tb) begin
                  r_state  <= TB_LOAD;
                  r_is_reg <= 1'b0;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
               end
            end
            RD_REQ:  r_state <= RD_WAIT;
            RD_WAIT: begin
               r_byte  <= i_rd_byte;
               r_state <= TX_LOAD;
            end
            TB_LOAD: begin
               r_byte  <= r_send[r_idx[2:0]];
               r_state <= TX_LOAD;
            end
            TX_LOAD: if (!i_tx_active) r_state <= TX_WAIT;
            TX_WAIT: begin
               if (i_tx_done) begin
                  if (w_last) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx <= r_idx + 8'd1;
                     if (r_is_reg) begin
                        r_state   <= RD_REQ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_idx + 8'd1;
                     end else begin
                        r_state <= TB_LOAD;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Strobe is decoded from state so the byte leaves in the same cycle uart_tx goes idle.
   assign o_tx_dv   = (r_state == TX_LOAD) && !i_tx_active;
   assign o_tx_byte = r_byte;
   assign o_rd_en   = r_rd_en;
   assign o_rd_addr = r_rd_addr;
   assign o_busy    = r_busy;

endmodule

// File: tb/tb_backchannel_ctrl.sv
// Randomised bench for backchannel_ctrl: regfile and uart_tx models plus a byte
// scoreboard predicting every transmitted byte and the cycle it must appear in.
module tb_backchannel_ctrl;
   localparam int N = 25;

   logic        i_clk_10 = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_rx_dv = 1'b0;
   logic [7:0]  i_rx_byte = '0;
   logic        o_tx_dv;
   logic [7:0]  o_tx_byte;
   logic        i_tx_active = 1'b0;
   logic        i_tx_done = 1'b0;
   logic        o_rd_en;
   logic [7:0]  o_rd_addr;
   logic [7:0]  i_rd_byte = '0;
   logic        i_thunder_packet_dv = 1'b0;
   logic [15:0] i_thunder_year = '0;
   logic [7:0]  i_thunder_month = '0;
   logic [7:0]  i_thunder_day = '0;
   logic [7:0]  i_thunder_hour = '0;
   logic [7:0]  i_thunder_minutes = '0;
   logic [7:0]  i_thunder_seconds = '0;
   logic        o_busy;

   backchannel_ctrl #(.FILE_SIZE_BYTES(N)) dut (
      .i_clk_10(i_clk_10), .i_rst_n(i_rst_n),
      .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
      .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_byte(i_rd_byte),
      .i_thunder_packet_dv(i_thunder_packet_dv), .i_thunder_year(i_thunder_year),
      .i_thunder_month(i_thunder_month), .i_thunder_day(i_thunder_day),
      .i_thunder_hour(i_thunder_hour), .i_thunder_minutes(i_thunder_minutes),
      .i_thunder_seconds(i_thunder_seconds), .o_busy(o_busy)
   );

   always #50 i_clk_10 = ~i_clk_10;

   int cyc = 0;
   always @(posedge i_clk_10) cyc <= cyc + 1;

   logic [7:0] mem [N];
   logic [7:0] sh [7];
   logic [7:0] exp_q [$];
   logic [7:0] e_byte;
   logic [7:0] rd_addr_seen;
   int n_checks = 0, n_errors = 0;
   int exp_total = 0, got_cnt = 0, exp_addr = 0, cur_lat = 0;
   int cmd_cyc = 0, done_cyc = 0, rel_cyc = 0, want_cyc = 0, tx_rem = 0, hold_rem = 0;
   bit dv_seen = 0, rd_seen = 0, stall_req = 0;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk_10);
      #1;
   endtask

   task automatic set_pkt(input logic [15:0] y, input logic [7:0] mo, d, h, mi, s);
      i_thunder_year = y; i_thunder_month = mo; i_thunder_day = d;
      i_thunder_hour = h; i_thunder_minutes = mi; i_thunder_seconds = s;
      sh[0] = y[15:8]; sh[1] = y[7:0]; sh[2] = mo; sh[3] = d;
      sh[4] = h; sh[5] = mi; sh[6] = s;
   endtask

   task automatic do_pkt(input logic [15:0] y, input logic [7:0] mo, d, h, mi, s);
      set_pkt(y, mo, d, h, mi, s);
      i_thunder_packet_dv = 1'b1;
      tick();
      i_thunder_packet_dv = 1'b0;
   endtask

   task automatic drive_rx(input logic [7:0] b);
      i_rx_dv = 1'b1;
      i_rx_byte = b;
      tick();
      i_rx_dv = 1'b0;
   endtask

   task automatic start_reg();
      exp_addr = 0;
      for (int k = 0; k < N; k++) begin
         exp_q.push_back(mem[k]);
         exp_total++;
      end
      cur_lat = 3;
      cmd_cyc = cyc;
      drive_rx(8'hAB);
      @(negedge i_clk_10);
      check_val("busy_rise_reg", o_busy, 1);
      tick();
   endtask

   task automatic start_tb(input bit with_pkt, input logic [15:0] y, input logic [7:0] mo, d, h, mi, s);
      if (with_pkt) begin
         set_pkt(y, mo, d, h, mi, s);
         i_thunder_packet_dv = 1'b1;
      end
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back(sh[k]);
         exp_total++;
      end
      cur_lat = 2;
      cmd_cyc = cyc;
      drive_rx(8'hAC);
      i_thunder_packet_dv = 1'b0;
      @(negedge i_clk_10);
      check_val("busy_rise_tb", o_busy, 1);
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 6000; i++) begin
         @(negedge i_clk_10);
         if (!o_busy) break;
      end
      check_val("busy_fall", o_busy, 0);
      check_val("bytes_left", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   task automatic wait_got(input int target);
      for (int i = 0; i < 3000; i++) begin
         @(negedge i_clk_10);
         if (got_cnt >= target) break;
      end
      check_val("wait_tx", int'(got_cnt >= target), 1);
      tick();
   endtask

   initial begin
      fork
         // uart_tx + regfile model: done 100 cycles after each load, read data one cycle after rd_en
         forever begin
            tick();
            i_tx_done = 1'b0;
            if (rd_seen) i_rd_byte = mem[rd_addr_seen];
            if (!i_rst_n) begin
               tx_rem = 0; hold_rem = 0; i_tx_active = 1'b0; rel_cyc = cyc;
            end else if (dv_seen) begin
               i_tx_active = 1'b1;
               tx_rem = 99;
            end else if (tx_rem > 0) begin
               tx_rem--;
               if (tx_rem == 0) begin
                  i_tx_done = 1'b1;
                  done_cyc = cyc;
                  if (stall_req) begin
                     stall_req = 0;
                     hold_rem = 50;
                  end else begin
                     i_tx_active = 1'b0;
                     rel_cyc = cyc;
                  end
               end
            end else if (hold_rem > 0) begin
               hold_rem--;
               if (hold_rem == 0) begin
                  i_tx_active = 1'b0;
                  rel_cyc = cyc;
               end
            end
         end
         // monitor
         forever begin
            @(negedge i_clk_10);
            dv_seen = o_tx_dv;
            rd_seen = o_rd_en;
            rd_addr_seen = o_rd_addr;
            if (o_rd_en) begin
               check_val("rd_addr", o_rd_addr, exp_addr);
               exp_addr++;
            end
            if (o_tx_dv) begin
               got_cnt++;
               $display("tx byte 0x%02h at cycle %0d", o_tx_byte, cyc);
               check_val("tx_extra", int'(got_cnt > exp_total), 0);
               check_val("tx_while_active", i_tx_active, 0);
               if (exp_q.size() > 0) begin
                  e_byte = exp_q.pop_front();
                  want_cyc = ((cmd_cyc > done_cyc) ? cmd_cyc : done_cyc) + cur_lat;
                  if (rel_cyc > want_cyc) want_cyc = rel_cyc;
                  check_val("tx_byte", o_tx_byte, e_byte);
                  check_val("tx_cycle", cyc, want_cyc);
               end
            end
         end
      join_none

      for (int k = 0; k < 7; k++) sh[k] = '0;
      repeat (3) tick();
      @(negedge i_clk_10);
      check_val("rst_tx_dv", o_tx_dv, 0);
      check_val("rst_tx_byte", o_tx_byte, 0);
      check_val("rst_rd_en", o_rd_en, 0);
      check_val("rst_rd_addr", o_rd_addr, 0);
      check_val("rst_busy", o_busy, 0);
      tick();
      i_rst_n = 1'b1;
      repeat (2) tick();

      // snapshot before any packet: seven zero bytes
      start_tb(0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      wait_idle();

      // fixed regfile dump
      for (int k = 0; k < N; k++) mem[k] = 8'(k + 16);
      start_reg();
      wait_idle();

      // fixed packet, then a newer packet while the dump is in flight
      do_pkt(16'h07E8, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56);
      start_tb(0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      wait_got(got_cnt + 3);
      do_pkt(16'h07E8, 8'd3, 8'd15, 8'd12, 8'd34, 8'd57);
      wait_idle();
      start_tb(0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      wait_idle();

      // random regfile; commands while busy are dropped; uart stays active after one done
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
      start_reg();
      wait_got(got_cnt + 2);
      drive_rx(8'hAB);
      wait_got(got_cnt + 2);
      drive_rx(8'h55);
      stall_req = 1;
      wait_got(got_cnt + 2);
      drive_rx(8'hAC);
      wait_idle();

      // random packets, odd iterations coincide with the command
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            do_pkt(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         start_tb(i % 2 == 1, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
         wait_idle();
      end

      // asynchronous reset in the middle of a regfile dump
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
      start_reg();
      wait_got(got_cnt + 10);
      repeat (20) tick();
      #20;
      i_rst_n = 1'b0;
      #1;
      check_val("arst_tx_dv", o_tx_dv, 0);
      check_val("arst_tx_byte", o_tx_byte, 0);
      check_val("arst_rd_en", o_rd_en, 0);
      check_val("arst_rd_addr", o_rd_addr, 0);
      check_val("arst_busy", o_busy, 0);
      exp_q.delete();
      exp_total = got_cnt;
      for (int k = 0; k < 7; k++) sh[k] = '0;
      repeat (3) tick();
      i_rst_n = 1'b1;
      repeat (200) tick();
      check_val("post_rst_quiet", got_cnt, exp_total);

      // shadow cleared by reset, then a fresh dump from address 0
      start_tb(0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      wait_idle();
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
      start_reg();
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
